tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Time-division demultiplexer. Receiver-side counterpart of the select-driven 2:1 / N:1 multiplexer components.
- Accepts a serial stream in which a transmitter mux has interleaved N_CH channels one slot per sample strobe, with a SYNC marker on channel 0.
- Tracks frame alignment with a small lock state machine and presents each complete frame as a parallel registered word with a one-cycle valid strobe.
- Sits in the components library next to the mux blocks, so mux-to-demux loopback benches can be built.

Parameters:
- W, 1, bit width of one channel sample.
- N_CH, 4, number of channels per frame. Legal range 2..16.
- SELW, 2, width of slot index. Must satisfy 2^SELW >= N_CH.

Ports:
- CLK  input  1  rising-edge clock, the only clock.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  sample strobe; DIN and SYNC are valid only when EN=1.
- DIN  input  W  current slot sample.
- SYNC  input  1  frame marker; high with EN on the channel-0 slot.
- DOUT  output  N_CH*W  last complete frame; channel k occupies bits [k*W +: W].
- FRAME_VALID  output  1  one-cycle pulse when DOUT is updated.
- SEL  output  SELW  slot index the next EN sample will be assigned to.
- LOCKED  output  1  high while in state LOCK.
- SYNC_ERR  output  1  one-cycle pulse on alignment violation.

Behaviour:
- Reset (asynchronous, RST=1), applied immediately:
  - state=HUNT, SEL=0, DOUT=0, FRAME_VALID=0, SYNC_ERR=0, LOCKED=0.
  - Shadow capture register cleared to 0.
- Cycles with EN=0: no state change. FRAME_VALID and SYNC_ERR return to 0. SYNC and DIN are ignored.
- State HUNT, on each edge with EN=1:
  - SYNC=0: sample discarded, SEL stays 0.
  - SYNC=1: DIN captured as channel 0, SEL<=1, state<=LOCK.
- State LOCK, on each edge with EN=1 (s = SEL):
  - s=0, SYNC=1: capture channel 0, SEL<=1.
  - s=0, SYNC=0: missing marker. SYNC_ERR pulses, state<=HUNT, SEL<=0, sample discarded, DOUT unchanged.
  - s in 1..N_CH-1, SYNC=1: early marker (resync). SYNC_ERR pulses, partial frame discarded, DIN captured as new channel 0, SEL<=1, state stays LOCK.
  - s in 1..N_CH-2, SYNC=0: capture channel s, SEL<=s+1.
  - s=N_CH-1, SYNC=0: capture last channel. DOUT<={DIN, shadow channels N_CH-2..0}, FRAME_VALID pulses, SEL wraps to 0.
- Latency: DOUT and FRAME_VALID change on the same edge that samples the last slot, visible after that edge (1 register stage). The complete frame is never exposed partially.
- DOUT holds its value between frames and across SYNC_ERR events. Only a full frame or RST changes it.
- LOCKED is a registered copy of (state==LOCK) and changes on the same edge as the state.
- SYNC_ERR and FRAME_VALID are never both high. The early-marker case discards the frame, so no FRAME_VALID is produced.
- Reset asserted mid-frame: partial frame lost, all outputs return to their reset values asynchronously. After release, the block re-enters HUNT.
- SEL never exceeds N_CH-1. It is 0 whenever state=HUNT.

Test Plan:
- Reset then lock: RST=1 for 2 cycles, release, EN=1, SYNC=1 on first sample, DIN sequence 1,0,1,1 (W=1, N_CH=4) -> LOCKED=1 after first edge, FRAME_VALID pulse after 4th edge, DOUT=4'b1101, SEL back to 0.
- Gapped strobes: same frame with EN=0 for 3 cycles between each slot -> identical DOUT=4'b1101, a single FRAME_VALID pulse, SEL holds during gaps.
- Missing marker: lock, complete one frame, next slot-0 sample has SYNC=0 -> SYNC_ERR pulse, LOCKED=0, SEL=0, DOUT retains 4'b1101.
- Early marker: lock, send 2 samples, then SYNC=1 on slot 2 with DIN=0, followed by 1,1,0 -> SYNC_ERR pulse, no FRAME_VALID for the aborted frame, next FRAME_VALID gives DOUT=4'b0110.
- HUNT ignores data: from reset, 5 samples with SYNC=0 -> LOCKED=0, SEL=0, DOUT=0, no pulses.
- Mid-frame reset: lock, send 2 samples, assert RST between edges -> DOUT=0, LOCKED=0, SEL=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tdm_demux.sv
// Purpose : time-division demultiplexer; splits an N_CH-slot serial stream
//           (SYNC marks channel 0) into registered parallel frames.
// Latency : 1 register stage; DOUT/FRAME_VALID update on the edge that samples the last slot.
// Backpr. : none; EN is a sample strobe and every EN=1 sample is consumed or discarded.
// Ports   : CLK/RST (async, active-high), EN/DIN/SYNC serial input,
//           DOUT/FRAME_VALID frame output, SEL/LOCKED/SYNC_ERR alignment status.
module tdm_demux #(
   parameter int W    = 1,
   parameter int N_CH = 4,
   parameter int SELW = 2
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                EN,
   input  logic [W-1:0]        DIN,
   input  logic                SYNC,
   output logic [N_CH*W-1:0]   DOUT,
   output logic                FRAME_VALID,
   output logic [SELW-1:0]     SEL,
   output logic                LOCKED,
   output logic                SYNC_ERR
);

   localparam logic [0:0] ST_HUNT = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

   localparam logic [SELW-1:0] SEL_FIRST = '0;
   localparam logic [SELW-1:0] SEL_ONE   = SELW'(1);
   localparam logic [SELW-1:0] SEL_LAST  = SELW'(N_CH - 1);

   logic [0:0]              state_q;
   logic [SELW-1:0]         sel_q;
   // Channels 0..N_CH-2 only; the last channel goes straight from DIN into
   // DOUT so a frame is published atomically on its final slot.
   logic [(N_CH-1)*W-1:0]   shadow_q;
   logic [N_CH*W-1:0]       dout_q;
   logic                    frame_valid_q;
   logic                    sync_err_q;
   logic                    locked_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= ST_HUNT;
         sel_q         <= SEL_FIRST;
         shadow_q      <= '0;
         dout_q        <= '0;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         // Status pulses last exactly one cycle.
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
         if (EN) begin
            case (state_q)
               ST_HUNT: begin
                  if (SYNC) begin
                     shadow_q[W-1:0] <= DIN;
                     sel_q           <= SEL_ONE;
                     state_q         <= ST_LOCK;
                     locked_q        <= 1'b1;
                  end
               end
               ST_LOCK: begin
                  if (sel_q == SEL_FIRST) begin
                     if (SYNC) begin
                        shadow_q[W-1:0] <= DIN;
                        sel_q           <= SEL_ONE;
                     end else begin
                        // Marker missing where expected: alignment lost.
                        sync_err_q <= 1'b1;
                        state_q    <= ST_HUNT;
                        locked_q   <= 1'b0;
                        sel_q      <= SEL_FIRST;
                     end
                  end else if (SYNC) begin
                     // Early marker: drop the partial frame and restart on
                     // this sample as channel 0, staying locked.
                     sync_err_q      <= 1'b1;
                     shadow_q[W-1:0] <= DIN;
                     sel_q           <= SEL_ONE;
                  end else if (sel_q == SEL_LAST) begin
                     dout_q        <= {DIN, shadow_q};
                     frame_valid_q <= 1'b1;
                     sel_q         <= SEL_FIRST;
                  end else begin
                     for (int k = 1; k < N_CH - 1; k++) begin
                        if (sel_q == SELW'(k)) begin
                           shadow_q[k*W +: W] <= DIN;
                        end
                     end
                     sel_q <= sel_q + SEL_ONE;
                  end
               end
               default: begin
                  state_q  <= ST_HUNT;
                  sel_q    <= SEL_FIRST;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign DOUT        = dout_q;
   assign FRAME_VALID = frame_valid_q;
   assign SEL         = sel_q;
   assign LOCKED      = locked_q;
   assign SYNC_ERR    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Purpose : self-checking bench for tdm_demux (W=1, N_CH=4).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpr. : none; inputs driven on falling edges.
module tb_tdm_demux;

   localparam int W    = 1;
   localparam int N_CH = 4;
   localparam int SELW = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en  = 1'b0;
   logic [W-1:0]      din = '0;
   logic              sync = 1'b0;
   logic [N_CH*W-1:0] dout;
   logic              frame_valid;
   logic [SELW-1:0]   sel;
   logic              locked;
   logic              sync_err;

   int checks   = 0;
   int failures = 0;

   tdm_demux #(.W(W), .N_CH(N_CH), .SELW(SELW)) dut (
      .CLK         (clk),
      .RST         (rst),
      .EN          (en),
      .DIN         (din),
      .SYNC        (sync),
      .DOUT        (dout),
      .FRAME_VALID (frame_valid),
      .SEL         (sel),
      .LOCKED      (locked),
      .SYNC_ERR    (sync_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic       en;
      logic       sync;
      logic       din;
      logic [3:0] dout;
      logic       fv;
      logic [1:0] sel;
      logic       lk;
      logic       err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic e, input logic s, input logic d,
                               input logic [3:0] o, input logic f, input logic [1:0] sl,
                               input logic l, input logic er);
      vec_t v;
      v.rst = r; v.en = e; v.sync = s; v.din = d;
      v.dout = o; v.fv = f; v.sel = sl; v.lk = l; v.err = er;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input logic r, input logic e, input logic s, input logic d);
      @(negedge clk);
      rst = r; en = e; sync = s; din = d;
      @(posedge clk);
      #1;
   endtask

   localparam logic [3:0] FR_A = 4'b1101;
   localparam logic [3:0] FR_B = 4'b0110;

   initial begin
      int fv_cnt;
      int err_cnt;
      logic [3:0] bits;

      // --- table-driven main sequence ---
      //                rst en sy d  dout  fv sel lk err
      vecs.push_back(mk(1, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 4'h0, 0, 1, 1, 0)); // lock on ch0
      vecs.push_back(mk(0, 1, 0, 0, 4'h0, 0, 2, 1, 0));
      vecs.push_back(mk(0, 1, 0, 1, 4'h0, 0, 3, 1, 0));
      vecs.push_back(mk(0, 1, 0, 1, FR_A, 1, 0, 1, 0)); // frame done
      vecs.push_back(mk(0, 0, 1, 0, FR_A, 0, 0, 1, 0)); // EN=0 idle, SYNC ignored
      vecs.push_back(mk(0, 1, 0, 1, FR_A, 0, 0, 0, 1)); // missing marker
      vecs.push_back(mk(0, 0, 0, 0, FR_A, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 1, FR_A, 0, 0, 0, 0)); // hunting
      vecs.push_back(mk(0, 1, 0, 0, FR_A, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, FR_A, 0, 1, 1, 0)); // relock
      vecs.push_back(mk(0, 1, 0, 1, FR_A, 0, 2, 1, 0));
      vecs.push_back(mk(0, 1, 1, 0, FR_A, 0, 1, 1, 1)); // early marker, new ch0=0
      vecs.push_back(mk(0, 1, 0, 1, FR_A, 0, 2, 1, 0));
      vecs.push_back(mk(0, 1, 0, 1, FR_A, 0, 3, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, FR_B, 1, 0, 1, 0)); // frame done
      vecs.push_back(mk(0, 0, 0, 0, FR_B, 0, 0, 1, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].rst, vecs[i].en, vecs[i].sync, vecs[i].din);
         check($sformatf("v%0d_dout", i),   32'(dout),        32'(vecs[i].dout));
         check($sformatf("v%0d_fv", i),     32'(frame_valid), 32'(vecs[i].fv));
         check($sformatf("v%0d_sel", i),    32'(sel),         32'(vecs[i].sel));
         check($sformatf("v%0d_locked", i), 32'(locked),      32'(vecs[i].lk));
         check($sformatf("v%0d_err", i),    32'(sync_err),    32'(vecs[i].err));
      end

      // --- gapped strobes: 3 idle cycles after every slot ---
      apply(1, 0, 0, 0);
      apply(1, 0, 0, 0);
      bits = 4'b1101; // ch0 in bit 0
      fv_cnt = 0;
      err_cnt = 0;
      for (int s = 0; s < N_CH; s++) begin
         apply(0, 1, (s == 0), bits[s]);
         if (frame_valid) fv_cnt++;
         if (sync_err) err_cnt++;
         for (int g = 0; g < 3; g++) begin
            apply(0, 0, 0, 0);
            if (frame_valid) fv_cnt++;
            if (sync_err) err_cnt++;
            check($sformatf("gap_s%0d_g%0d_sel", s, g), 32'(sel), 32'((s + 1) % N_CH));
         end
      end
      check("gap_dout",     32'(dout),   32'(FR_A));
      check("gap_fv_count", 32'(fv_cnt), 32'd1);
      check("gap_err_count",32'(err_cnt),32'd0);
      check("gap_locked",   32'(locked), 32'd1);

      // --- HUNT from reset ignores data ---
      apply(1, 0, 0, 0);
      apply(1, 0, 0, 0);
      fv_cnt = 0;
      err_cnt = 0;
      for (int s = 0; s < 5; s++) begin
         apply(0, 1, 0, 1'(s % 2 == 0));
         if (frame_valid) fv_cnt++;
         if (sync_err) err_cnt++;
         check($sformatf("hunt_s%0d_sel", s),    32'(sel),    32'd0);
         check($sformatf("hunt_s%0d_locked", s), 32'(locked), 32'd0);
      end
      check("hunt_dout",      32'(dout),    32'd0);
      check("hunt_fv_count",  32'(fv_cnt),  32'd0);
      check("hunt_err_count", 32'(err_cnt), 32'd0);

      // --- mid-frame asynchronous reset ---
      apply(0, 1, 1, 1);
      apply(0, 1, 0, 0);
      apply(0, 1, 0, 1);
      apply(0, 1, 0, 1);
      check("mfr_pre_dout", 32'(dout), 32'(FR_A));
      apply(0, 1, 1, 0);
      apply(0, 1, 0, 1);
      check("mfr_pre_sel",  32'(sel),  32'd2);
      @(negedge clk);
      en = 1'b0;
      rst = 1'b1;
      #1; // well before the next rising edge
      check("mfr_dout",   32'(dout),   32'd0);
      check("mfr_locked", 32'(locked), 32'd0);
      check("mfr_sel",    32'(sel),    32'd0);
      check("mfr_fv",     32'(frame_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      apply(0, 1, 0, 1);
      check("mfr_after_locked", 32'(locked), 32'd0);
      check("mfr_after_sel",    32'(sel),    32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
